// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
//
// Multiplies with a radix-2 shift-add over operand magnitudes and divides with
// restoring division. Each retires one bit per cycle over 32 CALC cycles. The
// sign fixup is applied on the way into DONE. Divide-by-zero and signed
// overflow skip CALC entirely.
//
// Ports:
//   clk_i     in   1      clock, rising edge
//   rst_ni    in   1      asynchronous active-low reset
//   start_i   in   1      current instruction is an M-extension op
//   funct3_i  in   3      operation select (MUL..REMU)
//   rs1_i     in   WIDTH  operand A (multiplicand / dividend)
//   rs2_i     in   WIDTH  operand B (multiplier / divisor)
//   stall_o   out  1      hold PC and register write while high
//   valid_o   out  1      one-cycle pulse, result_o valid
//   result_o  out  WIDTH  result, zero outside the valid cycle
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Datapath for one iteration, derived from the current state.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] calc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   calc_result;

  // Multiply: acc[63:32] collects partial sums, and the product shifts right
  // into acc[31:0]. The multiplier (b) shifts right one bit per cycle.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc[63:32] is the partial remainder and acc[31:0] collects
  // quotient bits. The dividend (a) shifts out MSB first.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_rem  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
  assign div_next = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

  assign calc_next = f3_q[2] ? div_next : mul_next;

  // Sign flags are only ever set for signed operands, so unsigned ops pass
  // through unchanged.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -calc_next : calc_next;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -calc_next[WIDTH-1:0] : calc_next[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -calc_next[2*WIDTH-1:WIDTH] : calc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    calc_result = rem_fix;
    unique case (f3_q)
      3'b000:                 calc_result = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_result = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         calc_result = quo_fix;
      default:                calc_result = rem_fix;
    endcase
  end

  // Operand signedness at acceptance. MUL is treated as signed, which leaves
  // the low product bits unchanged.
  logic sgn_a, sgn_b, rs1_neg, rs2_neg;
  assign sgn_a   = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010)
                || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sgn_b   = (funct3_i == 3'b000) || (funct3_i == 3'b001)
                || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign rs1_neg = sgn_a && rs1_i[WIDTH-1];
  assign rs2_neg = sgn_b && rs2_i[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    result_d = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          f3_d    = funct3_i;
          neg_a_d = rs1_neg;
          neg_b_d = rs2_neg;
          a_d     = rs1_neg ? -rs1_i : rs1_i;
          b_d     = rs2_neg ? -rs2_i : rs2_i;
          acc_d   = '0;
          cnt_d   = '0;
          if (funct3_i[2] && (rs2_i == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = funct3_i[1] ? rs1_i : '1;
          end else if (funct3_i[2] && !funct3_i[0]
                       && (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_i == '1)) begin
            // Signed overflow: quotient is the dividend, remainder is zero.
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = funct3_i[1] ? '0 : rs1_i;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = calc_next;
        a_d   = f3_q[2] ? (a_q << 1) : a_q;
        b_d   = f3_q[2] ? b_q : (b_q >> 1);
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH-1)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = calc_result;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Combinational so the PC freezes in the same cycle the instruction appears.
  assign stall_o  = ((state_q == IDLE) && start_i) || (state_q == CALC);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op and measures the cycle count, in instruction cycles, at
  // which valid_o appears. Operands and funct3 are scrambled after
  // acceptance. With hold=1, start_i stays high so the next op can follow at
  // once.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input bit hold);
    int lat;
    int stall_bad;
    funct3_i  = f3;
    rs1_i     = a;
    rs2_i     = b;
    start_i   = 1'b1;
    lat       = 0;
    stall_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (valid_o) begin
        lat = i;
        break;
      end
      if (!stall_o) stall_bad++;
      @(negedge clk_i);
      if (i == 1) begin
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        funct3_i = 3'($urandom);
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    check({tag, "_stall_busy"}, stall_bad, 32'd0);
    if (!hold) begin
      start_i = 1'b0;
      @(negedge clk_i);
      #1;
      check({tag, "_idle"}, {stall_o, valid_o, result_o[29:0]} | {2'b00, 30'(result_o >> 30)},
            32'd0);
    end else begin
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    funct3_i = 3'd0;
    rs1_i    = 32'd0;
    rs2_i    = 32'd0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    start_i = 1'b1;
    #1;
    check("rst_stall_start", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Multiplies
    do_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
    do_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
    do_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);
    do_op("mulh_m", 3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 34, 1'b0);

    // Divides
    do_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
    do_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
    do_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);
    do_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0);
    do_op("div_nd", 3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 34, 1'b0);

    // Special cases
    do_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 1'b0);
    do_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        2, 1'b0);
    do_op("divu0",  3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 2, 1'b0);
    do_op("remu0",  3'b111, 32'h12345678, 32'd0,        32'h12345678, 2, 1'b0);
    do_op("divov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
    do_op("remov",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2, 1'b0);

    // Reset at CALC cycle 10 with start_i held
    funct3_i = 3'b000;
    rs1_i    = 32'd7;
    rs2_i    = 32'hFFFFFFFD;
    start_i  = 1'b1;
    repeat (10) @(negedge clk_i);
    #1;
    check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    check("pre_rst_valid", {31'd0, valid_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_op("restart", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);

    // Back-to-back: MUL then DIVU with no gap
    do_op("b2b_mul",  3'b000, 32'd123, 32'd456, 32'd56088, 34, 1'b1);
    do_op("b2b_divu", 3'b101, 32'd1000, 32'd33, 32'd30,    34, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It sits directly downstream of the control unit. The control unit's `Mul_ext_o` flag (R-type, funct7[0]=1) drives `start_i`. The unit holds the PC and register-file write through `stall_o` until its 32-bit result is ready, then presents that result to the writeback mux for exactly one cycle.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk_i`  in  1  single clock, all state updates on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `start_i`  in  1  current instruction is an M-extension op (from `Mul_ext_o`)
- `funct3_i`  in  3  inst[14:12]; selects the operation
- `rs1_i`  in  32  operand A (dividend / multiplicand)
- `rs2_i`  in  32  operand B (divisor / multiplier)
- `stall_o`  out  1  freezes PC and suppresses register write while high
- `valid_o`  out  1  one-cycle pulse, `result_o` is valid
- `result_o`  out  32  operation result; held at 0 outside valid cycles

## Operation
- funct3 codes:
  - 000 MUL: low 32 bits
  - 001 MULH: signed×signed, high 32 bits
  - 010 MULHSU: signed rs1 × unsigned rs2, high 32 bits
  - 011 MULHU: high 32 bits
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- States: IDLE, CALC, DONE.
- IDLE with `start_i`=1: latch funct3, the operand signs, and the operands.
  - Operands flagged signed are converted to their magnitudes.
  - Clear the 64-bit accumulator; load the 6-bit counter with 0.
- IDLE → DONE directly (special cases, no CALC):
  - divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - Otherwise go to CALC.
- CALC, multiply: radix-2 shift-add over magnitudes, one multiplier bit per cycle, 64-bit product.
- CALC, divide: restoring division, one quotient bit per cycle, 32-bit quotient and remainder.
- CALC → DONE when the counter reaches 31 (32 CALC cycles).
- DONE: apply sign fixup and drive `result_o`, then unconditionally return to IDLE. `start_i` is ignored in DONE.
- Sign rules:
  - Product is negated if exactly one signed operand is negative.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops never negate.
- Back-to-back: if `start_i` is high in the IDLE cycle after DONE, the next operation is accepted (the PC has advanced).
- `funct3_i` and operands are sampled only at acceptance. Later changes are ignored.

## Timing
- Reset (any state, including mid-CALC): state=IDLE, counter=0, accumulators=0.
  - `valid_o`=0, `result_o`=0.
  - `stall_o`=0 unless `start_i`=1. A reset during CALC abandons the operation with no valid pulse.
- `stall_o` = (IDLE & `start_i`) | CALC. It is combinational, so it asserts in the same cycle the instruction first appears.
- `stall_o`=0 in DONE, so the instruction retires with the result that cycle.
- Normal op accepted at edge T: CALC for cycles T+1..T+32, DONE in T+33.
  - `valid_o`=1 for exactly that one cycle.
  - The instruction occupies 34 cycles total.
- Special case accepted at T: DONE in T+1; the instruction occupies 2 cycles.
- `valid_o` is registered (high only in DONE); `result_o` is registered and zero outside DONE.
- IDLE with `start_i`=0: no state change, all outputs 0.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result_o`=0xFFFFFFEB.
  - `stall_o` high for 33 cycles, then `valid_o` pulses once in cycle 34.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000. All three have `valid_o` in the second cycle.
- Reset mid-op: drop `rst_ni` at CALC cycle 10 with `start_i` held.
  - Outputs go 0 immediately.
  - After release, the op restarts and completes 34 cycles later with the correct result.
- Back-to-back MUL then DIVU with no gap:
  - two `valid_o` pulses 34 cycles apart
  - `stall_o` low only in each DONE cycle
  - operands changed during CALC do not affect the results
